// File: rtl/alarm_timer_ctrl.sv
// alarm_timer_ctrl: alarm-vs-time-of-day comparator and mm:ss countdown timer.
// It generates the ring/blink indications for the tone block and handles
// dismiss, snooze and ring timeout. The alarm and timer FSMs run independently.
// Every output comes from a flop, so an input in cycle N shows after the edge ending N.
module alarm_timer_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    input  logic       timer_load,
    input  logic [6:0] timer_set_min,
    input  logic [5:0] timer_set_sec,
    input  logic       timer_start,
    input  logic       timer_stop,
    input  logic       dismiss,
    input  logic       snooze,
    output logic       alarm_match,
    output logic       timer_match,
    output logic       blink_alarm,
    output logic       blink_timer,
    output logic       timer_running,
    output logic [6:0] timer_rem_min,
    output logic [5:0] timer_rem_sec
);

    typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} a_state_t;
    typedef enum logic [1:0] {T_IDLE, T_RUN, T_PAUSE, T_DONE} t_state_t;

    localparam logic [7:0] RING_LIM   = 8'(RING_SECS);
    localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SECS);

    a_state_t   a_state_q, a_state_d;
    t_state_t   t_state_q, t_state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [9:0] snz_cnt_q, snz_cnt_d;
    logic [7:0] t_ring_cnt_q, t_ring_cnt_d;
    logic       blink_alarm_q, blink_alarm_d;
    logic       blink_timer_q, blink_timer_d;
    logic       alarm_match_q, timer_match_q, timer_running_q;
    logic [6:0] rem_min_q, rem_min_d;
    logic [5:0] rem_sec_q, rem_sec_d;

    logic       alarm_hit;
    logic [7:0] ring_inc;
    logic [9:0] snz_inc;
    logic [7:0] t_ring_inc;
    logic [6:0] ld_min;
    logic [5:0] ld_sec;

    // Alarm FSM: match detection, ring timeout, snooze and dismiss handling.
    always_comb begin
        a_state_d     = a_state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        blink_alarm_d = blink_alarm_q;
        ring_inc      = ring_cnt_q + 8'd1;
        snz_inc       = snz_cnt_q + 10'd1;
        alarm_hit     = tick_1hz && (cur_hour == alarm_hour) &&
                        (cur_min == alarm_min) && (cur_sec == 6'd0);
        if (!alarm_en) begin
            a_state_d = A_IDLE;
        end else begin
            case (a_state_q)
                A_IDLE: begin
                    // dismiss is deliberately not consulted: a fresh match always rings
                    if (alarm_hit) begin
                        a_state_d     = A_RING;
                        ring_cnt_d    = 8'd0;
                        blink_alarm_d = 1'b0;
                    end
                end
                A_RING: begin
                    if (dismiss) begin
                        a_state_d = A_IDLE;
                    end else if (snooze) begin
                        a_state_d = A_SNOOZE;
                        snz_cnt_d = 10'd0;
                    end else if (tick_1hz) begin
                        blink_alarm_d = ~blink_alarm_q;
                        ring_cnt_d    = ring_inc;
                        if (ring_inc == RING_LIM) a_state_d = A_IDLE;
                    end
                end
                A_SNOOZE: begin
                    if (dismiss) begin
                        a_state_d = A_IDLE;
                    end else if (tick_1hz) begin
                        snz_cnt_d = snz_inc;
                        if (snz_inc == SNOOZE_LIM) begin
                            a_state_d  = A_RING;
                            ring_cnt_d = 8'd0;
                        end
                    end
                end
                default: a_state_d = A_IDLE;
            endcase
        end
        if (a_state_d != A_RING) blink_alarm_d = 1'b0;
    end

    // Timer FSM: load with clamping, start/stop, mm:ss countdown and done ringing.
    always_comb begin
        t_state_d     = t_state_q;
        rem_min_d     = rem_min_q;
        rem_sec_d     = rem_sec_q;
        t_ring_cnt_d  = t_ring_cnt_q;
        blink_timer_d = blink_timer_q;
        t_ring_inc    = t_ring_cnt_q + 8'd1;
        ld_min        = (timer_set_min > 7'd99) ? 7'd99 : timer_set_min;
        ld_sec        = (timer_set_sec > 6'd59) ? 6'd59 : timer_set_sec;
        case (t_state_q)
            T_IDLE, T_PAUSE: begin
                if (timer_load) begin
                    rem_min_d = ld_min;
                    rem_sec_d = ld_sec;
                end
                // start is judged on the freshly loaded value; stop overrides start
                if (timer_start && !timer_stop &&
                    ((rem_min_d != 7'd0) || (rem_sec_d != 6'd0))) begin
                    t_state_d = T_RUN;
                end
            end
            T_RUN: begin
                if (timer_stop) begin
                    t_state_d = T_PAUSE;
                end else if (tick_1hz) begin
                    if (rem_sec_q != 6'd0) begin
                        rem_sec_d = rem_sec_q - 6'd1;
                    end else begin
                        rem_min_d = rem_min_q - 7'd1;
                        rem_sec_d = 6'd59;
                    end
                    if ((rem_min_d == 7'd0) && (rem_sec_d == 6'd0)) begin
                        t_state_d     = T_DONE;
                        t_ring_cnt_d  = 8'd0;
                        blink_timer_d = 1'b0;
                    end
                end
            end
            T_DONE: begin
                if (dismiss) begin
                    t_state_d = T_IDLE;
                    rem_min_d = 7'd0;
                    rem_sec_d = 6'd0;
                end else if (timer_load) begin
                    t_state_d = T_IDLE;
                    rem_min_d = ld_min;
                    rem_sec_d = ld_sec;
                end else if (tick_1hz) begin
                    blink_timer_d = ~blink_timer_q;
                    t_ring_cnt_d  = t_ring_inc;
                    if (t_ring_inc == RING_LIM) begin
                        t_state_d = T_IDLE;
                        rem_min_d = 7'd0;
                        rem_sec_d = 6'd0;
                    end
                end
            end
            default: t_state_d = T_IDLE;
        endcase
        if (t_state_d != T_DONE) blink_timer_d = 1'b0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_q       <= A_IDLE;
            t_state_q       <= T_IDLE;
            ring_cnt_q      <= 8'd0;
            snz_cnt_q       <= 10'd0;
            t_ring_cnt_q    <= 8'd0;
            blink_alarm_q   <= 1'b0;
            blink_timer_q   <= 1'b0;
            alarm_match_q   <= 1'b0;
            timer_match_q   <= 1'b0;
            timer_running_q <= 1'b0;
            rem_min_q       <= 7'd0;
            rem_sec_q       <= 6'd0;
        end else begin
            a_state_q       <= a_state_d;
            t_state_q       <= t_state_d;
            ring_cnt_q      <= ring_cnt_d;
            snz_cnt_q       <= snz_cnt_d;
            t_ring_cnt_q    <= t_ring_cnt_d;
            blink_alarm_q   <= blink_alarm_d;
            blink_timer_q   <= blink_timer_d;
            alarm_match_q   <= (a_state_d == A_RING);
            timer_match_q   <= (t_state_d == T_DONE);
            timer_running_q <= (t_state_d == T_RUN);
            rem_min_q       <= rem_min_d;
            rem_sec_q       <= rem_sec_d;
        end
    end

    assign alarm_match   = alarm_match_q;
    assign timer_match   = timer_match_q;
    assign blink_alarm   = blink_alarm_q;
    assign blink_timer   = blink_timer_q;
    assign timer_running = timer_running_q;
    assign timer_rem_min = rem_min_q;
    assign timer_rem_sec = rem_sec_q;

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// tb_alarm_timer_ctrl: directed scenarios plus random traffic for alarm_timer_ctrl.
// At each rising edge a reference model, kept in plain seconds arithmetic, pushes
// the expected output vector. A monitor pops it at the next falling edge and compares.
module tb_alarm_timer_ctrl;
  localparam int RING = 60;
  localparam int SNZ  = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic [4:0] alarm_hour = '0;
  logic [5:0] alarm_min = '0;
  logic       alarm_en = 1'b0;
  logic       timer_load = 1'b0;
  logic [6:0] timer_set_min = '0;
  logic [5:0] timer_set_sec = '0;
  logic       timer_start = 1'b0;
  logic       timer_stop = 1'b0;
  logic       dismiss = 1'b0;
  logic       snooze = 1'b0;
  logic       alarm_match, timer_match, blink_alarm, blink_timer, timer_running;
  logic [6:0] timer_rem_min;
  logic [5:0] timer_rem_sec;

  // clock / reset block
  always #5 clk = ~clk;

  alarm_timer_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .timer_load(timer_load), .timer_set_min(timer_set_min), .timer_set_sec(timer_set_sec),
    .timer_start(timer_start), .timer_stop(timer_stop),
    .dismiss(dismiss), .snooze(snooze),
    .alarm_match(alarm_match), .timer_match(timer_match),
    .blink_alarm(blink_alarm), .blink_timer(blink_timer),
    .timer_running(timer_running),
    .timer_rem_min(timer_rem_min), .timer_rem_sec(timer_rem_sec)
  );

  // scoreboard
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;
  int n_tests = 0;
  int n_fail  = 0;
  int tod = 0;

  // reference model: alarm ringing / snoozing with seconds left, timer as total seconds
  bit m_ring, m_snoozing, m_blink_a;
  int m_ring_left, m_snz_left;
  bit m_run, m_done, m_blink_t;
  int m_trem, m_done_left;

  function automatic logic [17:0] dut_vec();
    return {alarm_match, timer_match, blink_alarm, blink_timer, timer_running,
            timer_rem_min, timer_rem_sec};
  endfunction

  function automatic logic [17:0] model_vec();
    return {m_ring, m_done, m_blink_a, m_blink_t, m_run,
            7'(m_trem / 60), 6'(m_trem % 60)};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got am=%b tm=%b ba=%b bt=%b run=%b rem=%0d:%0d, expected am=%b tm=%b ba=%b bt=%b run=%b rem=%0d:%0d",
               name, $time, act[17], act[16], act[15], act[14], act[13], act[12:6], act[5:0],
               exp[17], exp[16], exp[15], exp[14], exp[13], exp[12:6], exp[5:0]);
    end
  endtask

  task automatic model_reset();
    m_ring = 0; m_snoozing = 0; m_blink_a = 0; m_ring_left = 0; m_snz_left = 0;
    m_run = 0; m_done = 0; m_blink_t = 0; m_trem = 0; m_done_left = 0;
  endtask

  task automatic model_step();
    int ld;
    bit hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hit = tick_1hz && (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 0);
    if (!alarm_en) begin
      m_ring = 0; m_snoozing = 0;
    end else if (m_ring) begin
      if (dismiss) m_ring = 0;
      else if (snooze) begin m_ring = 0; m_snoozing = 1; m_snz_left = SNZ; end
      else if (tick_1hz) begin
        m_blink_a = ~m_blink_a;
        m_ring_left--;
        if (m_ring_left == 0) m_ring = 0;
      end
    end else if (m_snoozing) begin
      if (dismiss) m_snoozing = 0;
      else if (tick_1hz) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_snoozing = 0; m_ring = 1; m_ring_left = RING; end
      end
    end else if (hit) begin
      m_ring = 1; m_ring_left = RING; m_blink_a = 0;
    end
    if (!m_ring) m_blink_a = 0;

    ld = ((timer_set_min > 99) ? 99 : int'(timer_set_min)) * 60 +
         ((timer_set_sec > 59) ? 59 : int'(timer_set_sec));
    if (m_done) begin
      if (dismiss) begin m_done = 0; m_trem = 0; end
      else if (timer_load) begin m_done = 0; m_trem = ld; end
      else if (tick_1hz) begin
        m_blink_t = ~m_blink_t;
        m_done_left--;
        if (m_done_left == 0) begin m_done = 0; m_trem = 0; end
      end
    end else if (m_run) begin
      if (timer_stop) m_run = 0;
      else if (tick_1hz) begin
        m_trem--;
        if (m_trem == 0) begin m_run = 0; m_done = 1; m_done_left = RING; m_blink_t = 0; end
      end
    end else begin
      if (timer_load) m_trem = ld;
      if (timer_start && !timer_stop && m_trem > 0) m_run = 1;
    end
    if (!m_done) m_blink_t = 0;
  endtask

  // monitor: compare DUT outputs against the entry pushed at the preceding edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("outputs", dut_vec(), mon_exp);
      end
    end
  end

  // driver tasks
  task automatic set_tod(input int s);
    tod = s % 86400;
    cur_hour = 5'(tod / 3600);
    cur_min  = 6'((tod / 60) % 60);
    cur_sec  = 6'(tod % 60);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_vec());
    #1;
    tick_1hz = 0; timer_load = 0; timer_start = 0; timer_stop = 0;
    dismiss = 0; snooze = 0;
  endtask

  task automatic sec_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1;
      cycle();
      set_tod(tod + 1);
      repeat ($urandom_range(1, 3)) cycle();
    end
  endtask

  task automatic load_timer(input int mm, input int ss);
    timer_set_min = 7'(mm);
    timer_set_sec = 6'(ss);
    timer_load = 1;
    cycle();
  endtask

  task automatic pulse_start();
    timer_start = 1;
    cycle();
  endtask

  // stimulus
  initial begin
    model_reset();
    #1 rst_n = 0;
    #1 check("reset_async", dut_vec(), 18'd0);
    repeat (2) cycle();
    #2 rst_n = 1;
    repeat (2) cycle();

    // alarm trigger at 07:30:00 and timeout after RING ticks
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1;
    set_tod(7 * 3600 + 29 * 60 + 59);
    sec_tick(2);
    sec_tick(RING + 2);

    // snooze then re-ring, then dismiss
    alarm_hour = 5'd8; alarm_min = 6'd0;
    set_tod(7 * 3600 + 59 * 60 + 59);
    sec_tick(3);
    snooze = 1; cycle();
    sec_tick(SNZ + 2);
    dismiss = 1; cycle();
    cycle();

    // timer countdown 01:02 to done and ring timeout
    load_timer(1, 2);
    pulse_start();
    sec_tick(62 + RING + 2);

    // zero start ignored, clamp on load, pause/resume
    timer_set_min = 0; timer_set_sec = 0; timer_load = 1; timer_start = 1; cycle();
    sec_tick(2);
    load_timer(120, 63);
    load_timer(0, 5);
    pulse_start();
    sec_tick(2);
    timer_stop = 1; cycle();
    sec_tick(10);
    timer_start = 1; timer_stop = 1; cycle();
    sec_tick(1);
    pulse_start();
    sec_tick(4);
    dismiss = 1; cycle();

    // alarm ring and timer done on the same tick; dismiss+snooze together
    alarm_hour = 5'd9; alarm_min = 6'd0;
    set_tod(8 * 3600 + 59 * 60 + 58);
    load_timer(0, 3);
    pulse_start();
    sec_tick(4);
    dismiss = 1; snooze = 1; cycle();
    sec_tick(SNZ + 5);

    // reset in the middle of a ring and a countdown
    alarm_hour = 5'd10; alarm_min = 6'd0;
    set_tod(9 * 3600 + 59 * 60 + 59);
    load_timer(0, 30);
    pulse_start();
    sec_tick(3);
    #1 rst_n = 0;
    exp_q.delete();
    model_reset();
    #1 check("reset_midop", dut_vec(), 18'd0);
    repeat (3) cycle();
    #2 rst_n = 1;
    sec_tick(5);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      bit t;
      if (c % 200 == 0) begin
        alarm_hour = 5'(((tod + 60) / 3600) % 24);
        alarm_min  = 6'(((tod + 60) / 60) % 60);
      end
      if ($urandom_range(0, 399) == 0) alarm_en = ~alarm_en;
      t = ($urandom_range(0, 2) == 0);
      tick_1hz = t;
      if ($urandom_range(0, 24) == 0) begin
        timer_load = 1;
        if ($urandom_range(0, 3) == 0) begin
          timer_set_min = 7'($urandom_range(0, 127));
          timer_set_sec = 6'($urandom_range(0, 63));
        end else begin
          timer_set_min = 7'($urandom_range(0, 1));
          timer_set_sec = 6'($urandom_range(0, 63));
        end
      end
      timer_start = ($urandom_range(0, 7) == 0);
      timer_stop  = ($urandom_range(0, 19) == 0);
      dismiss     = ($urandom_range(0, 59) == 0);
      snooze      = ($urandom_range(0, 39) == 0);
      cycle();
      if (t) set_tod(tod + 1);
    end

    cycle();
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
